tron_plot_scheduler: RTL and testbench



---
 rtl/tron_pkg.sv | 13 +
 rtl/tron_clear_sweep.sv | 27 ++
 rtl/tron_plot_scheduler.sv | 107 ++++++++++
 tb/tb_tron_plot_scheduler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tron_pkg.sv
// tron_pkg: shared state encoding, arena bounds, screen size and colour constants for the tron plot path.
package tron_pkg;
   typedef enum logic [1:0] {CLEAR, IDLE, P0, P1} state_t;
   localparam logic [7:0] X_MIN_DEF = 8'd10;
   localparam logic [7:0] X_MAX_DEF = 8'd150;
   localparam logic [6:0] Y_MIN_DEF = 7'd17;
   localparam logic [6:0] Y_MAX_DEF = 7'd109;
   localparam int SCR_W = 160;
   localparam int SCR_H = 120;
   localparam logic [2:0] BG_COL = 3'b000;
   localparam logic [2:0] A_COL = 3'b001;
   localparam logic [2:0] B_COL = 3'b100;
endpackage

// File: rtl/tron_clear_sweep.sv
// tron_clear_sweep: raster scan of the whole screen, x fastest, one pixel per cycle from reset or start.
module tron_clear_sweep
   import tron_pkg::*;
(
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       start,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic       valid,
   output logic       done
);
   logic last_x, last_y;
   assign last_x = x == 8'(SCR_W - 1);
   assign last_y = y == 7'(SCR_H - 1);
   assign done = valid & last_x & last_y;
   always_ff @(posedge CLOCK_50)
      if (!resetn || start) begin
         x <= '0;
         y <= '0;
         valid <= 1'b1;
      end else if (valid) begin
         x <= last_x ? 8'd0 : x + 8'd1;
         y <= last_x ? (last_y ? 7'd0 : y + 7'd1) : y;
         valid <= !done;
      end
endmodule

// File: rtl/tron_plot_scheduler.sv
// tron_plot_scheduler: per-tick two-slot plot arbitration with bounds/head-on death tracking.
// Define TRON_CLEAR_EN to sweep the framebuffer to BG_COLOUR after every reset.
module tron_plot_scheduler
   import tron_pkg::*;
#(
   parameter logic [7:0] X_MIN = X_MIN_DEF,
   parameter logic [7:0] X_MAX = X_MAX_DEF,
   parameter logic [6:0] Y_MIN = Y_MIN_DEF,
   parameter logic [6:0] Y_MAX = Y_MAX_DEF,
   parameter logic [2:0] BG_COLOUR = BG_COL
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       tick,
   input  logic [7:0] a_x,
   input  logic [7:0] b_x,
   input  logic [6:0] a_y,
   input  logic [6:0] b_y,
   input  logic [2:0] a_colour,
   input  logic [2:0] b_colour,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot,
   output logic       busy,
   output logic       dead_a,
   output logic       dead_b,
   output logic       overrun
);
`ifdef TRON_CLEAR_EN
   localparam state_t RST_STATE = CLEAR;
`else
   localparam state_t RST_STATE = IDLE;
`endif
   state_t state, state_d;
   logic prio, acc, out_a, out_b, hit, dead_a_d, dead_b_d, plot_d, lat_live;
   logic [7:0] x_d, lat_x, sx;
   logic [6:0] y_d, lat_y, sy;
   logic [2:0] c_d, lat_c;
   logic sv, sdone;
`ifdef TRON_CLEAR_EN
   tron_clear_sweep u_sweep (
      .CLOCK_50(CLOCK_50),
      .resetn(resetn),
      .start(1'b0),
      .x(sx),
      .y(sy),
      .valid(sv),
      .done(sdone)
   );
`else
   assign sx = '0;
   assign sy = '0;
   assign sv = 1'b0;
   assign sdone = 1'b0;
`endif
   assign busy = state != IDLE;
   always_ff @(posedge CLOCK_50)
      if (!resetn) begin
         state <= RST_STATE;
         vga_x <= '0;
         vga_y <= '0;
         vga_colour <= '0;
         vga_plot <= 1'b0;
         dead_a <= 1'b0;
         dead_b <= 1'b0;
         overrun <= 1'b0;
         prio <= 1'b0;
         lat_x <= '0;
         lat_y <= '0;
         lat_c <= '0;
         lat_live <= 1'b0;
      end else begin
         state <= state_d;
         vga_x <= x_d;
         vga_y <= y_d;
         vga_colour <= c_d;
         vga_plot <= plot_d;
         dead_a <= dead_a_d;
         dead_b <= dead_b_d;
         overrun <= overrun | (tick & (state == P0 || state == P1));
         prio <= prio ^ acc;
         if (acc) begin
            lat_x <= prio ? a_x : b_x;
            lat_y <= prio ? a_y : b_y;
            lat_c <= prio ? a_colour : b_colour;
            lat_live <= prio ? !dead_a_d : !dead_b_d;
         end
      end
   always_comb
      state_d = state == CLEAR ? (sdone ? IDLE : CLEAR) :
                state == IDLE  ? (tick ? P0 : IDLE) :
                state == P0    ? P1 : IDLE;
   // The first slot is presented on the accepting edge, so it is built straight from the inputs.
   always_comb begin
      out_a = a_x < X_MIN || a_x > X_MAX || a_y < Y_MIN || a_y > Y_MAX;
      out_b = b_x < X_MIN || b_x > X_MAX || b_y < Y_MIN || b_y > Y_MAX;
      hit = a_x == b_x && a_y == b_y && !dead_a && !dead_b;
      acc = state == IDLE && tick;
      dead_a_d = dead_a | (acc & (out_a | hit));
      dead_b_d = dead_b | (acc & (out_b | hit));
      x_d = state == CLEAR ? sx : acc ? (prio ? b_x : a_x) : state == P0 ? lat_x : vga_x;
      y_d = state == CLEAR ? sy : acc ? (prio ? b_y : a_y) : state == P0 ? lat_y : vga_y;
      c_d = state == CLEAR ? BG_COLOUR : acc ? (prio ? b_colour : a_colour) : state == P0 ? lat_c : vga_colour;
      plot_d = state == CLEAR ? sv : acc ? (prio ? !dead_b_d : !dead_a_d) : state == P0 && lat_live;
   end
endmodule

// File: tb/tb_tron_plot_scheduler.sv
// tb_tron_plot_scheduler: directed and randomized checks of the plot scheduler against a slot-queue model.
module tb_tron_plot_scheduler;
   import tron_pkg::*;
`ifdef TRON_CLEAR_EN
   localparam int CLR_LEN = 19200;
`else
   localparam int CLR_LEN = 0;
`endif
   typedef struct {
      logic       plot;
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } slot_t;

   logic CLOCK_50 = 1'b0, resetn = 1'b0, tick = 1'b0;
   logic [7:0] a_x = '0, b_x = '0;
   logic [6:0] a_y = '0, b_y = '0;
   logic [2:0] a_colour = A_COL, b_colour = B_COL;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic vga_plot, busy, dead_a, dead_b, overrun;
   int n_tests = 0, n_fail = 0;

   always #5 CLOCK_50 = ~CLOCK_50;

   tron_plot_scheduler dut (
      .CLOCK_50(CLOCK_50), .resetn(resetn), .tick(tick),
      .a_x(a_x), .b_x(b_x), .a_y(a_y), .b_y(b_y),
      .a_colour(a_colour), .b_colour(b_colour),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
      .busy(busy), .dead_a(dead_a), .dead_b(dead_b), .overrun(overrun)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a queue of slots to be presented, one per edge; ticks are accepted only when nothing is pending.
   slot_t q[$];
   slot_t s;
   int m_clear = CLR_LEN, m_busy = 0, pix;
   logic m_prio = 0, m_da = 0, m_db = 0, m_ov = 0, oa, ob, hit;
   logic e_plot = 0, e_load = 1, e_busy = (CLR_LEN > 0);
   logic [7:0] e_x = 0;
   logic [6:0] e_y = 0;
   logic [2:0] e_c = 0;

   always @(posedge CLOCK_50) begin
      if (!resetn) begin
         q.delete();
         m_clear = CLR_LEN;
         m_busy = 0;
         m_prio = 0;
         m_da = 0;
         m_db = 0;
         m_ov = 0;
         e_plot = 0;
         e_load = 1;
         e_x = 0;
         e_y = 0;
         e_c = 0;
      end else begin
         if (m_clear > 0) begin
            pix = CLR_LEN - m_clear;
            q.push_back('{1'b1, 8'(pix % 160), 7'(pix / 160), 3'b000});
            m_clear--;
         end else if (tick && m_busy > 0) m_ov = 1;
         else if (tick) begin
            oa = a_x < 10 || a_x > 150 || a_y < 17 || a_y > 109;
            ob = b_x < 10 || b_x > 150 || b_y < 17 || b_y > 109;
            hit = a_x == b_x && a_y == b_y && !m_da && !m_db;
            m_da = m_da | oa | hit;
            m_db = m_db | ob | hit;
            if (m_prio) begin
               q.push_back('{!m_db, b_x, b_y, b_colour});
               q.push_back('{!m_da, a_x, a_y, a_colour});
            end else begin
               q.push_back('{!m_da, a_x, a_y, a_colour});
               q.push_back('{!m_db, b_x, b_y, b_colour});
            end
            m_prio = !m_prio;
            m_busy = 3;
         end
         if (m_busy > 0) m_busy--;
         if (q.size() > 0) begin
            s = q.pop_front();
            e_plot = s.plot;
            e_load = 1;
            e_x = s.x;
            e_y = s.y;
            e_c = s.c;
         end else begin
            e_plot = 0;
            e_load = 0;
         end
      end
      e_busy = m_clear > 0 || m_busy > 0;
   end

   always @(negedge CLOCK_50) begin
      chk("plot", vga_plot, e_plot);
      chk("busy", busy, e_busy);
      chk("dead_a", dead_a, m_da);
      chk("dead_b", dead_b, m_db);
      chk("overrun", overrun, m_ov);
      if (e_load) begin
         chk("x", vga_x, e_x);
         chk("y", vga_y, e_y);
         chk("colour", vga_colour, e_c);
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 25000 && busy; i++) @(negedge CLOCK_50);
      chk("idle_timeout", busy, 0);
   endtask

   task automatic reset_dut();
      @(negedge CLOCK_50);
      resetn = 0;
      tick = 0;
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      resetn = 1;
      @(negedge CLOCK_50);
      wait_idle();
   endtask

   task automatic heads(input int ax, input int ay, input int bx, input int by);
      a_x = 8'(ax);
      a_y = 7'(ay);
      b_x = 8'(bx);
      b_y = 7'(by);
   endtask

   initial begin
      reset_dut();
      chk("rst_dead_a", dead_a, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_plot", vga_plot, 0);
      heads(25, 25, 100, 100);
      tick = 1;
      @(negedge CLOCK_50);
      tick = 0;
      chk("s1_plot", vga_plot, 1);
      chk("s1_x", vga_x, 25);
      chk("s1_y", vga_y, 25);
      chk("s1_c", vga_colour, 1);
      chk("s1_busy", busy, 1);
      @(negedge CLOCK_50);
      chk("s2_plot", vga_plot, 1);
      chk("s2_x", vga_x, 100);
      chk("s2_c", vga_colour, 4);
      @(negedge CLOCK_50);
      chk("s3_plot", vga_plot, 0);
      chk("s3_busy", busy, 0);
      heads(30, 30, 40, 40);
      tick = 1;
      @(negedge CLOCK_50);
      tick = 0;
      chk("swap1_x", vga_x, 40);
      chk("swap1_c", vga_colour, 4);
      @(negedge CLOCK_50);
      chk("swap2_x", vga_x, 30);
      @(negedge CLOCK_50);
      heads(50, 20, 51, 20);
      tick = 1;
      @(negedge CLOCK_50);
      chk("ov1_x", vga_x, 50);
      @(negedge CLOCK_50);
      tick = 0;
      chk("ov_flag", overrun, 1);
      chk("ov2_x", vga_x, 51);
      @(negedge CLOCK_50);
      chk("ov3_plot", vga_plot, 0);
      heads(60, 30, 70, 30);
      tick = 1;
      @(negedge CLOCK_50);
      tick = 0;
      chk("k3_plot", vga_plot, 1);
      chk("k3_x", vga_x, 70);
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      heads(9, 50, 80, 50);
      tick = 1;
      @(negedge CLOCK_50);
      tick = 0;
      chk("die_dead_a", dead_a, 1);
      chk("die_plot_a", vga_plot, 0);
      chk("die_x", vga_x, 9);
      @(negedge CLOCK_50);
      chk("die_plot_b", vga_plot, 1);
      chk("die_xb", vga_x, 80);
      @(negedge CLOCK_50);
      heads(40, 40, 90, 90);
      tick = 1;
      @(negedge CLOCK_50);
      tick = 0;
      chk("ghost_b", vga_x, 90);
      @(negedge CLOCK_50);
      chk("ghost_a_plot", vga_plot, 0);
      @(negedge CLOCK_50);
      heads(20, 20, 30, 30);
      tick = 1;
      @(negedge CLOCK_50);
      tick = 0;
      resetn = 0;
      @(negedge CLOCK_50);
      chk("mid_rst_plot", vga_plot, 0);
      chk("mid_rst_dead_a", dead_a, 0);
      chk("mid_rst_ov", overrun, 0);
      chk("mid_rst_x", vga_x, 0);
      chk("mid_rst_busy", busy, CLR_LEN > 0);
      resetn = 1;
      wait_idle();
      heads(60, 60, 60, 60);
      tick = 1;
      @(negedge CLOCK_50);
      tick = 0;
      chk("hit_dead_a", dead_a, 1);
      chk("hit_dead_b", dead_b, 1);
      chk("hit_plot1", vga_plot, 0);
      @(negedge CLOCK_50);
      chk("hit_plot2", vga_plot, 0);
      reset_dut();
      for (int i = 0; i < 600; i++) begin
         @(negedge CLOCK_50);
         heads($urandom_range(155, 5), $urandom_range(114, 12), $urandom_range(155, 5), $urandom_range(114, 12));
         if ($urandom_range(3, 0) == 0) begin
            b_x = a_x;
            b_y = a_y;
         end
         a_colour = 3'($urandom_range(7, 0));
         b_colour = 3'($urandom_range(7, 0));
         tick = $urandom_range(2, 0) == 0;
`ifndef TRON_CLEAR_EN
         resetn = $urandom_range(40, 0) != 0;
`endif
      end
      @(negedge CLOCK_50);
      tick = 0;
      resetn = 1;
      wait_idle();
      @(negedge CLOCK_50);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
